mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Multi-cycle MIPS main control FSM. It produces the 3-bit ALUOp consumed by the ALU controller, plus the datapath enables and mux selects.
- Sits between the instruction register (opcode) and the multi-cycle datapath.
- Moore FSM with a memory-ready handshake on every memory access.

Parameters:
- ST_W, 4, state register width (state_o width).

Ports:
- clk_i  in  1  system clock, all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- opcode_i  in  6  IR[31:26], stable outside FETCH
- mem_ready_i  in  1  memory access complete this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero (beq)
- i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- ir_write_o  out  1  IR load
- mem_to_reg_o  out  1  write-back data: 0=ALUOut, 1=MDR
- reg_dst_o  out  1  destination register: 0=rt, 1=rd
- reg_write_o  out  1  register file write
- alu_src_a_o  out  1  ALU A: 0=PC, 1=A register
- alu_src_b_o  out  2  ALU B select:
  - 00 = B register
  - 01 = constant 4
  - 10 = sign-extended immediate
  - 11 = sign-extended immediate << 2
- alu_op_o  out  3  ALUOp:
  - 0 = add
  - 1 = sub
  - 2 = R-type (funct decides)
  - 3 = slt
- pc_source_o  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- halted_o  out  1  illegal opcode seen, sticky
- state_o  out  ST_W  current state, for debug

Behaviour:
- Reset: rst_i high at an edge → state IDLE, overriding any in-flight access; a stall is abandoned with no write. In IDLE all outputs are 0. IDLE → FETCH on the next edge with rst_i low.
- Outputs are combinational from state, plus mem_ready_i gating in FETCH only. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, src_a=0, src_b=01, alu_op=0, pc_source=00.
  - Also ir_write=1 and pc_write=1 only while mem_ready_i=1.
  - Holds while mem_ready_i=0; → DECODE when ready.
- DECODE:
  - Outputs: src_a=0, src_b=11, alu_op=0 (branch target into ALUOut).
  - Transition by opcode:
    - 0x00 → EXEC_R
    - 0x08 / 0x0A → EXEC_I
    - 0x23 / 0x2B → ADDR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - anything else → HALT
- EXEC_R: src_a=1, src_b=00, alu_op=2 → WB_R.
- WB_R: reg_dst=1, reg_write=1 → FETCH.
- EXEC_I: src_a=1, src_b=10; alu_op=0 for 0x08, 3 for 0x0A → WB_I.
- WB_I: reg_dst=0, reg_write=1 → FETCH.
- ADDR: src_a=1, src_b=10, alu_op=0 → MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: i_or_d=1, mem_read=1; hold until mem_ready_i → WB_MEM.
- WB_MEM: mem_to_reg=1, reg_dst=0, reg_write=1 → FETCH.
- MEM_WR: i_or_d=1, mem_write=1; hold until mem_ready_i → FETCH. mem_write stays asserted for the whole stall.
- BRANCH: src_a=1, src_b=00, alu_op=1, pc_write_cond=1, pc_source=01 → FETCH.
- JUMP: pc_write=1, pc_source=10 → FETCH.
- HALT: halted_o=1, all other outputs 0; absorbing until reset.
- Instruction latency with zero wait states:
  - R/I-type 4 cycles
  - lw 5
  - sw 4
  - beq 3
  - j 3
- Each wait cycle adds exactly 1 cycle.
- mem_ready_i is ignored outside FETCH/MEM_RD/MEM_WR.
- Undefined state encodings → IDLE.

Optional Feature:
- Macro MC_BNE_EN.
- Defined:
  - opcode 0x05 (bne) decodes to BRANCH_NE, which drives the BRANCH outputs plus output branch_ne_o=1 (datapath inverts zero) → FETCH.
  - branch_ne_o is 0 in every other state.
- Undefined: port branch_ne_o is absent and 0x05 → HALT.

Decomposition:
- Package mc_pkg:
  - opcode constants
  - ALUOp encodings 0–3
  - ALUSrcB and PCSource encodings
  - state enum: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, BRANCH_NE, JUMP, HALT
- Sub-module mc_out_decode: pure state (+mem_ready_i) → control-vector decode. The top keeps the state register and next-state logic.

Test Plan:
- Reset, then add R-type (opcode 0x00), ready always 1 → states IDLE, FETCH, DECODE, EXEC_R, WB_R, FETCH; alu_op=2 in EXEC_R; reg_dst=1, reg_write=1 in WB_R.
- lw (0x23) with 2 wait cycles in FETCH and 3 in MEM_RD → total 10 cycles.
  - ir_write and pc_write pulse exactly once.
  - mem_read is high for all 4 MEM_RD cycles.
  - WB_MEM shows mem_to_reg=1.
- slti (0x0A) → alu_op=3 in EXEC_I; addi (0x08) → alu_op=0. beq (0x04) → alu_op=1, pc_write_cond=1, pc_source=01 for one cycle.
- j (0x02) → pc_write=1, pc_source=10 in JUMP. sw (0x2B) with ready=0 for 2 cycles → mem_write high for 3 cycles, reg_write never high.
- Opcode 0x3F → HALT, halted_o=1 for 20 cycles; rst_i pulsed mid-MEM_WR stall → IDLE next edge, mem_write=0.
- MC_BNE_EN defined: 0x05 → BRANCH_NE with branch_ne_o=1. Undefined: 0x05 → halted_o=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants, state encoding and control-vector type for the multi-cycle MIPS main control.
// Optional bne support is enabled by defining MC_BNE_EN.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_RTYPE = 3'd2;
  localparam logic [2:0] ALU_SLT   = 3'd3;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    EXEC_R    = 4'd3,
    WB_R      = 4'd4,
    EXEC_I    = 4'd5,
    WB_I      = 4'd6,
    ADDR      = 4'd7,
    MEM_RD    = 4'd8,
    WB_MEM    = 4'd9,
    MEM_WR    = 4'd10,
    BRANCH    = 4'd11,
    BRANCH_NE = 4'd12,
    JUMP      = 4'd13,
    HALT      = 4'd14
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
`ifdef MC_BNE_EN
    logic       branch_ne;
`endif
  } ctrl_t;

  // Instruction class dispatch out of DECODE; unknown opcodes park the controller in HALT.
  function automatic state_e decode_op(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE:         nxt = EXEC_R;
      OP_ADDI, OP_SLTI: nxt = EXEC_I;
      OP_LW, OP_SW:     nxt = ADDR;
      OP_BEQ:           nxt = BRANCH;
`ifdef MC_BNE_EN
      OP_BNE:           nxt = BRANCH_NE;
`endif
      OP_J:             nxt = JUMP;
      default:          nxt = HALT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Opcode/handshake inputs and datapath control outputs of the main control FSM.
// branch_ne_o exists only when MC_BNE_EN is defined.
interface mc_main_ctrl_if #(parameter int ST_W = 4);
  logic [5:0]      opcode_i;
  logic            mem_ready_i;
  logic            pc_write_o;
  logic            pc_write_cond_o;
  logic            i_or_d_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            ir_write_o;
  logic            mem_to_reg_o;
  logic            reg_dst_o;
  logic            reg_write_o;
  logic            alu_src_a_o;
  logic [1:0]      alu_src_b_o;
  logic [2:0]      alu_op_o;
  logic [1:0]      pc_source_o;
  logic            halted_o;
  logic [ST_W-1:0] state_o;
`ifdef MC_BNE_EN
  logic            branch_ne_o;
`endif

  modport master (
    input  opcode_i, mem_ready_i,
`ifdef MC_BNE_EN
    output branch_ne_o,
`endif
    output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, pc_source_o, halted_o, state_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
`ifdef MC_BNE_EN
    input  branch_ne_o,
`endif
    input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
           ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
           alu_src_b_o, alu_op_o, pc_source_o, halted_o, state_o
  );
endinterface

// File: rtl/mc_out_decode.sv
// Moore output decode: state (plus mem_ready_i in FETCH, opcode in EXEC_I) to control vector.
// BRANCH_NE outputs are decoded only when MC_BNE_EN is defined.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready_i,
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC load only on the cycle the instruction word actually arrives.
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
      end
      DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_RTYPE;
      end
      WB_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      WB_I: begin
        ctrl.reg_write = 1'b1;
      end
      ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      WB_MEM: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
`ifdef MC_BNE_EN
      BRANCH_NE: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = 1'b1;
      end
`endif
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: state register and next-state logic; outputs via mc_out_decode.
// Define MC_BNE_EN to add the bne (BRANCH_NE) path and the branch_ne_o output.
//
// state     | meaning
// IDLE      | after reset, all outputs low
// FETCH     | instruction read, PC+4; waits on mem_ready_i
// DECODE    | branch target into ALUOut, dispatch on opcode
// EXEC_R    | R-type ALU operation
// WB_R      | write ALUOut to rd
// EXEC_I    | addi/slti ALU operation
// WB_I      | write ALUOut to rt
// ADDR      | lw/sw effective address
// MEM_RD    | data read; waits on mem_ready_i
// WB_MEM    | write MDR to rt
// MEM_WR    | data write; waits on mem_ready_i
// BRANCH    | beq compare and conditional PC load
// BRANCH_NE | bne compare (MC_BNE_EN only)
// JUMP      | PC load from jump target
// HALT      | illegal opcode, absorbing until reset
module mc_main_ctrl
  import mc_pkg::*;
#(
  parameter int ST_W = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  mc_main_ctrl_if.master bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (bus.mem_ready_i) state_d = DECODE;
      DECODE: state_d = decode_op(bus.opcode_i);
      EXEC_R: state_d = WB_R;
      WB_R:   state_d = FETCH;
      EXEC_I: state_d = WB_I;
      WB_I:   state_d = FETCH;
      ADDR:   state_d = (bus.opcode_i == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: if (bus.mem_ready_i) state_d = WB_MEM;
      WB_MEM: state_d = FETCH;
      MEM_WR: if (bus.mem_ready_i) state_d = FETCH;
      BRANCH: state_d = FETCH;
`ifdef MC_BNE_EN
      BRANCH_NE: state_d = FETCH;
`endif
      JUMP:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  mc_out_decode u_out_decode (
    .state       (state_q),
    .mem_ready_i (bus.mem_ready_i),
    .opcode_i    (bus.opcode_i),
    .ctrl        (ctrl)
  );

  assign bus.pc_write_o      = ctrl.pc_write;
  assign bus.pc_write_cond_o = ctrl.pc_write_cond;
  assign bus.i_or_d_o        = ctrl.i_or_d;
  assign bus.mem_read_o      = ctrl.mem_read;
  assign bus.mem_write_o     = ctrl.mem_write;
  assign bus.ir_write_o      = ctrl.ir_write;
  assign bus.mem_to_reg_o    = ctrl.mem_to_reg;
  assign bus.reg_dst_o       = ctrl.reg_dst;
  assign bus.reg_write_o     = ctrl.reg_write;
  assign bus.alu_src_a_o     = ctrl.alu_src_a;
  assign bus.alu_src_b_o     = ctrl.alu_src_b;
  assign bus.alu_op_o        = ctrl.alu_op;
  assign bus.pc_source_o     = ctrl.pc_source;
  assign bus.halted_o        = ctrl.halted;
  assign bus.state_o         = ST_W'(state_q);
`ifdef MC_BNE_EN
  assign bus.branch_ne_o     = ctrl.branch_ne;
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: instruction-level expectation queue plus DUT-observed counters.
// Build with MC_BNE_EN defined to exercise the bne path.
module tb_mc_main_ctrl;
  import mc_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  mc_main_ctrl_if #(.ST_W(4)) bus ();
  mc_main_ctrl #(.ST_W(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       branch_ne;
  } tvec_t;

  typedef struct {
    state_e st;
    tvec_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic counting = 1'b0;
  int   c_cyc, c_ir, c_pcw, c_pcwc, c_mr, c_mr_rd, c_mw, c_rw, c_m2r, c_halt, c_bne;

  // What the control lines must be in a given step of an instruction, straight from the rule table.
  function automatic tvec_t expect_of(state_e s, logic rdy, logic [5:0] op);
    tvec_t v = '0;
    case (s)
      FETCH:  begin v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
      DECODE: v.alu_src_b = 2'b11;
      EXEC_R: begin v.alu_src_a = 1; v.alu_op = 3'd2; end
      WB_R:   begin v.reg_dst = 1; v.reg_write = 1; end
      EXEC_I: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_op = (op == 6'h0A) ? 3'd3 : 3'd0; end
      WB_I:   v.reg_write = 1;
      ADDR:   begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      MEM_RD: begin v.i_or_d = 1; v.mem_read = 1; end
      WB_MEM: begin v.mem_to_reg = 1; v.reg_write = 1; end
      MEM_WR: begin v.i_or_d = 1; v.mem_write = 1; end
      BRANCH: begin v.alu_src_a = 1; v.alu_op = 3'd1; v.pc_write_cond = 1; v.pc_source = 2'b01; end
      BRANCH_NE: begin
        v.alu_src_a = 1; v.alu_op = 3'd1; v.pc_write_cond = 1; v.pc_source = 2'b01; v.branch_ne = 1;
      end
      JUMP:   begin v.pc_write = 1; v.pc_source = 2'b10; end
      HALT:   v.halted = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic tvec_t dut_vec();
    tvec_t a;
    a.pc_write      = bus.pc_write_o;
    a.pc_write_cond = bus.pc_write_cond_o;
    a.i_or_d        = bus.i_or_d_o;
    a.mem_read      = bus.mem_read_o;
    a.mem_write     = bus.mem_write_o;
    a.ir_write      = bus.ir_write_o;
    a.mem_to_reg    = bus.mem_to_reg_o;
    a.reg_dst       = bus.reg_dst_o;
    a.reg_write     = bus.reg_write_o;
    a.alu_src_a     = bus.alu_src_a_o;
    a.alu_src_b     = bus.alu_src_b_o;
    a.alu_op        = bus.alu_op_o;
    a.pc_source     = bus.pc_source_o;
    a.halted        = bus.halted_o;
`ifdef MC_BNE_EN
    a.branch_ne     = bus.branch_ne_o;
`else
    a.branch_ne     = 1'b0;
`endif
    return a;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin : cmp
    exp_t  e;
    tvec_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = dut_vec();
      chk($sformatf("ctrl@%s", e.st.name()), 32'(a), 32'(e.v));
      chk("state", 32'(bus.state_o), 32'(e.st));
    end
    if (counting) begin
      c_cyc++;
      c_ir    += int'(bus.ir_write_o);
      c_pcw   += int'(bus.pc_write_o);
      c_pcwc  += int'(bus.pc_write_cond_o);
      c_mr    += int'(bus.mem_read_o);
      c_mr_rd += int'(bus.mem_read_o && bus.state_o == 4'(MEM_RD));
      c_mw    += int'(bus.mem_write_o);
      c_rw    += int'(bus.reg_write_o);
      c_m2r   += int'(bus.mem_to_reg_o);
      c_halt  += int'(bus.halted_o);
`ifdef MC_BNE_EN
      c_bne   += int'(bus.branch_ne_o);
`endif
    end
  end

  // One clock of stimulus: drive inputs just after the edge and queue what this cycle must show.
  task automatic step(state_e s, logic rdy, logic rst);
    exp_t e;
    rst_i           = rst;
    bus.mem_ready_i = rdy;
    e.st = s;
    e.v  = expect_of(s, rdy, bus.opcode_i);
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic run_insn(logic [5:0] op, int fw, int mw);
    bus.opcode_i = op;
    c_cyc = 0; c_ir = 0; c_pcw = 0; c_pcwc = 0; c_mr = 0; c_mr_rd = 0;
    c_mw = 0; c_rw = 0; c_m2r = 0; c_halt = 0; c_bne = 0;
    counting = 1'b1;
    for (int i = 0; i < fw; i++) step(FETCH, 1'b0, 1'b0);
    step(FETCH, 1'b1, 1'b0);
    step(DECODE, rnd_bit(), 1'b0);
    case (op)
      6'h00: begin step(EXEC_R, rnd_bit(), 1'b0); step(WB_R, rnd_bit(), 1'b0); end
      6'h08, 6'h0A: begin step(EXEC_I, rnd_bit(), 1'b0); step(WB_I, rnd_bit(), 1'b0); end
      6'h23: begin
        step(ADDR, rnd_bit(), 1'b0);
        for (int i = 0; i < mw; i++) step(MEM_RD, 1'b0, 1'b0);
        step(MEM_RD, 1'b1, 1'b0);
        step(WB_MEM, rnd_bit(), 1'b0);
      end
      6'h2B: begin
        step(ADDR, rnd_bit(), 1'b0);
        for (int i = 0; i < mw; i++) step(MEM_WR, 1'b0, 1'b0);
        step(MEM_WR, 1'b1, 1'b0);
      end
      6'h04: step(BRANCH, rnd_bit(), 1'b0);
      6'h02: step(JUMP, rnd_bit(), 1'b0);
`ifdef MC_BNE_EN
      6'h05: step(BRANCH_NE, rnd_bit(), 1'b0);
`endif
      default: for (int i = 0; i < 20; i++) step(HALT, rnd_bit(), 1'b0);
    endcase
    counting = 1'b0;
  endtask

  task automatic reset_from(state_e s);
    step(s, 1'b0, 1'b1);
    step(IDLE, 1'b0, 1'b0);
  endtask

  logic [5:0] legal_ops [7] = '{6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02};

  initial begin
    rst_i = 1'b1;
    bus.opcode_i = 6'h00;
    bus.mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    step(IDLE, 1'b1, 1'b1);
    step(IDLE, 1'b1, 1'b0);

    run_insn(6'h00, 0, 0);
    chk("rtype_cycles", 32'(c_cyc), 32'd4);
    chk("rtype_reg_write", 32'(c_rw), 32'd1);

    run_insn(6'h23, 2, 3);
    chk("lw_cycles", 32'(c_cyc), 32'd10);
    chk("lw_ir_write", 32'(c_ir), 32'd1);
    chk("lw_pc_write", 32'(c_pcw), 32'd1);
    chk("lw_mem_read_in_mem_rd", 32'(c_mr_rd), 32'd4);
    chk("lw_mem_read_total", 32'(c_mr), 32'd7);
    chk("lw_mem_to_reg", 32'(c_m2r), 32'd1);

    run_insn(6'h0A, 0, 0);
    chk("slti_cycles", 32'(c_cyc), 32'd4);
    run_insn(6'h08, 1, 0);
    chk("addi_cycles", 32'(c_cyc), 32'd5);
    run_insn(6'h04, 0, 0);
    chk("beq_cycles", 32'(c_cyc), 32'd3);
    chk("beq_pc_write_cond", 32'(c_pcwc), 32'd1);
    run_insn(6'h02, 0, 0);
    chk("j_cycles", 32'(c_cyc), 32'd3);
    chk("j_pc_write", 32'(c_pcw), 32'd2);
    run_insn(6'h2B, 0, 2);
    chk("sw_cycles", 32'(c_cyc), 32'd6);
    chk("sw_mem_write", 32'(c_mw), 32'd3);
    chk("sw_reg_write", 32'(c_rw), 32'd0);

    for (int n = 0; n < 40; n++) begin
      run_insn(legal_ops[$urandom_range(0, 6)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a write stall abandons the write.
    bus.opcode_i = 6'h2B;
    step(FETCH, 1'b1, 1'b0);
    step(DECODE, 1'b0, 1'b0);
    step(ADDR, 1'b0, 1'b0);
    step(MEM_WR, 1'b0, 1'b0);
    step(MEM_WR, 1'b0, 1'b0);
    reset_from(MEM_WR);
    chk("post_reset_mem_write", 32'(bus.mem_write_o), 32'd0);
    run_insn(6'h08, 0, 0);

    run_insn(6'h3F, 0, 0);
    chk("halt_cycles", 32'(c_halt), 32'd20);
    reset_from(HALT);

    run_insn(6'h11, 1, 0);
    chk("halt_rnd_op", 32'(c_halt), 32'd20);
    reset_from(HALT);

    run_insn(6'h05, 0, 0);
`ifdef MC_BNE_EN
    chk("bne_cycles", 32'(c_cyc), 32'd3);
    chk("bne_flag", 32'(c_bne), 32'd1);
`else
    chk("bne_halts", 32'(c_halt), 32'd20);
    reset_from(HALT);
`endif
    run_insn(6'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
